// File: rtl/sorter_pipe.sv
// sorter_pipe: pipelined odd-even transposition sorter, one register rank per network stage.
// Define SORTER_PIPE_INDEX_EN to add out_idx, the original input position of each output element.
module sorter_pipe #(
  parameter int unsigned N  = 5,
  parameter int unsigned DW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_desc,
  input  logic [DW*N-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW*N-1:0]       out_data
`ifdef SORTER_PIPE_INDEX_EN
  ,
  output logic [$clog2(N)*N-1:0] out_idx
`endif
);

  localparam int unsigned VW = DW * N;
`ifdef SORTER_PIPE_INDEX_EN
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned TW = IW * N;
`endif

  logic          w_adv;
  logic [VW-1:0] w_stg_in   [N];
  logic [VW-1:0] w_stg_out  [N];
  logic          w_stg_desc [N];

  logic [VW-1:0] r_data [N];
  logic [N-1:0]  r_valid;
  logic          r_desc [N];

`ifdef SORTER_PIPE_INDEX_EN
  logic [TW-1:0] w_idx_init;
  logic [TW-1:0] w_stg_idx_in  [N];
  logic [TW-1:0] w_stg_idx_out [N];
  logic [TW-1:0] r_idx [N];

  // Fresh tags 0..N-1 enter with every vector
  always_comb begin
    w_idx_init = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx_init[IW*k +: IW] = IW'(k);
    end
  end
`endif

  // Whole pipe advances together; a full output register stalls everything
  assign w_adv    = !r_valid[N-1] || out_ready;
  assign in_ready = w_adv;

  for (genvar s = 0; s < N; s++) begin : g_stage
    logic [VW-1:0] w_cx;
    logic [DW-1:0] w_lo;
    logic [DW-1:0] w_hi;
`ifdef SORTER_PIPE_INDEX_EN
    logic [TW-1:0] w_cx_idx;
`endif

    if (s == 0) begin : g_head
      assign w_stg_in[s]   = in_data;
      assign w_stg_desc[s] = in_desc;
`ifdef SORTER_PIPE_INDEX_EN
      assign w_stg_idx_in[s] = w_idx_init;
`endif
    end else begin : g_body
      assign w_stg_in[s]   = r_data[s-1];
      assign w_stg_desc[s] = r_desc[s-1];
`ifdef SORTER_PIPE_INDEX_EN
      assign w_stg_idx_in[s] = r_idx[s-1];
`endif
    end

    // Compare-exchange on pairs (j, j+1) with j matching the stage parity
    always_comb begin
      w_cx = w_stg_in[s];
      w_lo = '0;
      w_hi = '0;
`ifdef SORTER_PIPE_INDEX_EN
      w_cx_idx = w_stg_idx_in[s];
`endif
      for (int unsigned j = s % 2; j + 1 < N; j += 2) begin
        w_lo = w_stg_in[s][DW*j +: DW];
        w_hi = w_stg_in[s][DW*(j+1) +: DW];
        if (w_stg_desc[s] ? (w_lo < w_hi) : (w_lo > w_hi)) begin
          w_cx[DW*j +: DW]     = w_hi;
          w_cx[DW*(j+1) +: DW] = w_lo;
`ifdef SORTER_PIPE_INDEX_EN
          w_cx_idx[IW*j +: IW]     = w_stg_idx_in[s][IW*(j+1) +: IW];
          w_cx_idx[IW*(j+1) +: IW] = w_stg_idx_in[s][IW*j +: IW];
`endif
        end
      end
    end

    assign w_stg_out[s] = w_cx;
`ifdef SORTER_PIPE_INDEX_EN
    assign w_stg_idx_out[s] = w_cx_idx;
`endif
  end

  // Stage registers: data, valid and order bit move in lockstep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int unsigned s = 0; s < N; s++) begin
        r_data[s] <= '0;
        r_desc[s] <= 1'b0;
`ifdef SORTER_PIPE_INDEX_EN
        r_idx[s]  <= '0;
`endif
      end
    end else if (w_adv) begin
      r_valid <= {r_valid[N-2:0], in_valid};
      for (int unsigned s = 0; s < N; s++) begin
        r_data[s] <= w_stg_out[s];
        r_desc[s] <= w_stg_desc[s];
`ifdef SORTER_PIPE_INDEX_EN
        r_idx[s]  <= w_stg_idx_out[s];
`endif
      end
    end
  end

  assign out_valid = r_valid[N-1];
  assign out_data  = r_data[N-1];
`ifdef SORTER_PIPE_INDEX_EN
  assign out_idx   = r_idx[N-1];
`endif

endmodule

// File: tb/tb_sorter_pipe.sv
// tb_sorter_pipe: directed and random stimulus with a stable-sort reference and a result queue.
// Builds with or without SORTER_PIPE_INDEX_EN; index checks are active only when it is defined.
module tb_sorter_pipe;

  localparam int unsigned N  = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned VW = N * DW;
  localparam int unsigned IW = 3;
  localparam int unsigned TW = N * IW;

  typedef struct packed {
    logic [VW-1:0] d;
    logic [TW-1:0] ix;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_desc, out_valid, out_ready;
  logic [VW-1:0] in_data, out_data;
  logic          d2_in_valid, d2_in_ready, d2_out_valid;
  logic [1:0]    d2_in_data, d2_out_data;
`ifdef SORTER_PIPE_INDEX_EN
  logic [TW-1:0] out_idx;
  logic [1:0]    d2_out_idx;
`endif

  int   n_chk = 0;
  int   n_err = 0;
  logic [N-1:0] m_v;
  exp_t sb[$];

  always #5 clk = ~clk;

  sorter_pipe #(.N(N), .DW(DW)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_desc(in_desc), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef SORTER_PIPE_INDEX_EN
    , .out_idx(out_idx)
`endif
  );

  sorter_pipe #(.N(2), .DW(1)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_desc(1'b0), .in_data(d2_in_data),
    .out_valid(d2_out_valid), .out_ready(1'b1), .out_data(d2_out_data)
`ifdef SORTER_PIPE_INDEX_EN
    , .out_idx(d2_out_idx)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stable insertion sort: equal keys keep their input order
  function automatic exp_t ref_sort(input logic [VW-1:0] x, input logic desc);
    logic [DW-1:0] k  [N];
    logic [IW-1:0] ix [N];
    logic [DW-1:0] tk;
    logic [IW-1:0] ti;
    int            j;
    exp_t          r;
    for (int i = 0; i < N; i++) begin
      k[i]  = x[DW*i +: DW];
      ix[i] = IW'(i);
    end
    for (int i = 1; i < N; i++) begin
      tk = k[i];
      ti = ix[i];
      j  = i - 1;
      while (j >= 0) begin
        if (desc ? (k[j] < tk) : (k[j] > tk)) begin
          k[j+1]  = k[j];
          ix[j+1] = ix[j];
          j--;
        end else break;
      end
      k[j+1]  = tk;
      ix[j+1] = ti;
    end
    for (int i = 0; i < N; i++) begin
      r.d[DW*i +: DW]  = k[i];
      r.ix[IW*i +: IW] = ix[i];
    end
    return r;
  endfunction

  // One clock of the main DUT: drive, check against model and queue, then clock
  task automatic step(input logic v, input logic d, input logic [VW-1:0] x,
                      input logic ordy, output logic acc);
    logic adv;
    in_valid  = v;
    in_desc   = d;
    in_data   = x;
    out_ready = ordy;
    #1;
    adv = !m_v[N-1] || ordy;
    chk("in_ready", 64'(in_ready), 64'(adv));
    chk("out_valid", 64'(out_valid), 64'(m_v[N-1]));
    if (m_v[N-1]) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $error("FAIL sb_underflow observed=valid expected=empty");
      end else begin
        chk("out_data", 64'(out_data), 64'(sb[0].d));
`ifdef SORTER_PIPE_INDEX_EN
        chk("out_idx", 64'(out_idx), 64'(sb[0].ix));
`endif
        if (ordy) void'(sb.pop_front());
      end
    end
    acc = v && adv;
    if (acc) sb.push_back(ref_sort(x, d));
    if (adv) m_v = {m_v[N-2:0], v};
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic v, input logic d, input logic [VW-1:0] x, input logic ordy);
    logic acc;
    step(v, d, x, ordy, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (sb.size() != 0 || m_v != '0); i++) st(1'b0, 1'b0, '0, 1'b1);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[DW*i +: DW] = 8'($urandom);
    return r;
  endfunction

  initial begin
    logic [VW-1:0] cur;
    logic          acc;
    int            sent;
    int            recv;
    int            sz;

    rst = 1'b1; in_valid = 1'b0; in_desc = 1'b0; in_data = '0; out_ready = 1'b0;
    d2_in_valid = 1'b0; d2_in_data = '0;
    m_v = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef SORTER_PIPE_INDEX_EN
    chk("rst_out_idx", 64'(out_idx), 64'd0);
`endif
    rst = 1'b0;

    // N=2, DW=1: inputs (1,0) then (0,1), both sort to (0,1)
    d2_in_valid = 1'b1; d2_in_data = 2'b01;
    @(posedge clk); #1;
    d2_in_data = 2'b10;
    @(posedge clk); #1;
    d2_in_valid = 1'b0;
    chk("n2_v0", 64'(d2_out_valid), 64'd1);
    chk("n2_d0", 64'(d2_out_data), 64'h2);
    @(posedge clk); #1;
    chk("n2_v1", 64'(d2_out_valid), 64'd1);
    chk("n2_d1", 64'(d2_out_data), 64'h2);
    @(posedge clk); #1;
    chk("n2_idle", 64'(d2_out_valid), 64'd0);

    // 9,3,7,1,5 ascending then descending on the next cycle
    st(1'b1, 1'b0, 40'h0501070309, 1'b1);
    st(1'b1, 1'b1, 40'h0501070309, 1'b1);
    repeat (3) st(1'b0, 1'b0, '0, 1'b1);
    chk("asc_lat_valid", 64'(out_valid), 64'd1);
    chk("asc_data", 64'(out_data), 64'h0907050301);
    st(1'b0, 1'b0, '0, 1'b1);
    chk("desc_data", 64'(out_data), 64'h0103050709);
    drain();

    // Duplicate keys 4,4,0,255,4 ascending
    st(1'b1, 1'b0, 40'h04FF000404, 1'b1);
    repeat (4) st(1'b0, 1'b0, '0, 1'b1);
    chk("dup_data", 64'(out_data), 64'hFF04040400);
`ifdef SORTER_PIPE_INDEX_EN
    chk("dup_idx", 64'(out_idx), 64'h3842);
`endif
    drain();

    // Extreme values and all-equal keys, both orders, back to back
    st(1'b1, 1'b0, 40'h80FF00FF00, 1'b1);
    st(1'b1, 1'b1, 40'h80FF00FF00, 1'b1);
    st(1'b1, 1'b0, 40'hFFFFFFFFFF, 1'b1);
    st(1'b1, 1'b1, 40'h0000000000, 1'b1);
    st(1'b1, 1'b1, 40'h00FF0100FE, 1'b1);
    drain();

    // 20 random vectors, out_ready one cycle on, two off
    sent = 0;
    recv = 0;
    cur  = rnd_vec();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (sent == 20 && sb.size() == 0 && m_v == '0) break;
      sz = sb.size();
      step(sent < 20, 1'($urandom), cur, (cyc % 3) == 0, acc);
      recv += sz + (acc ? 1 : 0) - sb.size();
      if (acc) begin
        sent++;
        cur = rnd_vec();
      end
    end
    chk("stream_sent", 64'(sent), 64'd20);
    chk("stream_recv", 64'(recv), 64'd20);

    // Reset with three vectors in flight
    for (int i = 0; i < 3; i++) st(1'b1, 1'(i), rnd_vec(), 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", 64'(out_data), 64'd0);
    m_v = '0;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) st(1'b0, 1'b0, '0, 1'b1);
    st(1'b1, 1'b1, 40'h0A14001E05, 1'b1);
    repeat (4) st(1'b0, 1'b0, '0, 1'b1);
    chk("postrst_valid", 64'(out_valid), 64'd1);
    chk("postrst_data", 64'(out_data), 64'h00050A141E);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sorter_pipe.md
Name: sorter_pipe

Overview:
- Pipelined, parametrised N-element sorter built as an odd-even transposition network, one register rank per network stage.
- Accepts one packed vector per cycle through a valid/ready handshake and returns it sorted, ascending or descending, selected per vector.
- Replaces the earlier combinational sorter wherever sort results feed clocked datapaths at full throughput.

Parameters:
- N, 5, number of elements per vector; legal range 2..64.
- DW, 8, element width in bits; elements are unsigned.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input vector present.
- in_ready  output  1  block can accept a vector this cycle.
- in_desc  input  1  sort order for this vector: 0 = ascending, 1 = descending.
- in_data  input  DW*N  packed vector; element k at in_data[DW*k +: DW].
- out_valid  output  1  sorted vector present.
- out_ready  input  1  downstream accepts the output this cycle.
- out_data  output  DW*N  sorted vector; element 0 at [DW-1:0]. Ascending: element 0 is the smallest. Descending: element 0 is the largest.

Behaviour:
- Pipeline has N stages. Stage s (s = 0..N-1) compares adjacent pairs (j, j+1) for all j with j mod 2 == s mod 2 and j+1 < N.
- Per pair, in ascending mode: swap iff elem[j] > elem[j+1]. In descending mode: swap iff elem[j] < elem[j+1].
- Comparisons are strict, so equal keys never swap and the sort is stable.
- Each stage registers three values: data, a valid bit, and the desc bit. The desc bit travels with its vector, so mixed-order vectors may be in flight at once.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational). When adv = 0, every stage holds.
- When adv = 1, each stage loads from its predecessor, and stage 0 loads {in_data, in_valid, in_desc}.
- A vector is accepted on a cycle where in_valid && in_ready.
- Latency: exactly N cycles from acceptance to out_valid with no stalls. Throughput is one vector per cycle.
- out_data and out_valid come directly from the final stage registers; there is no combinational path from in_data to out_data.
- Bubbles (valid = 0) propagate like data. Bubbles do not collapse under stall, since the whole pipe freezes.
- Reset: all valid bits = 0, all data registers = 0, all desc bits = 0. Immediately after reset, out_valid = 0, out_data = 0 and in_ready = 1.
- Reset asserted mid-operation discards every in-flight vector with no partial output. The first vector after deassertion follows the normal N-cycle latency.
- While out_valid = 1 and out_ready = 0, out_data and out_valid stay stable until the transfer completes.
- Simultaneous input accept and output transfer in the same cycle is legal and loses nothing.
- Data of invalid stages is don't-care internally, but out_data = 0 is required only at reset.

Optional Feature:
- Macro SORTER_PIPE_INDEX_EN.
- When defined, the block adds output out_idx, width IW*N, with IW = $clog2(N). out_idx[IW*k +: IW] is the original input position of the element at out_data position k.
- Index tags are generated at stage 0 as 0..N-1 and swap together with their data. The indices form a permutation; the equal-key order follows from stability. out_idx resets to 0.
- When not defined, the out_idx port and all tag registers are absent. Data behaviour is identical in both builds.

Test Plan:
- N=5, DW=8, in_data elements e0..e4 = 9,3,7,1,5, in_desc=0, out_ready=1 -> after exactly 5 cycles out_valid=1 with elements 1,3,5,7,9.
- Same vector with in_desc=1, sent on the cycle after the ascending one -> consecutive outputs 1,3,5,7,9 then 9,7,5,3,1.
- Duplicates 4,4,0,255,4 with SORTER_PIPE_INDEX_EN, ascending -> data 0,4,4,4,255 and out_idx 2,0,1,4,3 (stability).
- Stream of 20 random vectors with out_ready toggling in a 1-on/2-off pattern -> all 20 outputs sorted, in order, none dropped or duplicated; out_data stays stable during each stall; in_ready mirrors adv.
- Assert rst for 1 cycle with 3 vectors in flight -> out_valid=0 next cycle, none of the 3 vectors ever appears, and a new vector emerges 5 cycles after acceptance.
- N=2, DW=1, inputs 1,0 and 0,1 ascending -> output 0,1 for both; boundary values 0xFF / 0x00 are handled at N=5.
